mask_serializer_core: RTL and testbench
=======================================

# mask_serializer_core

Parallel-to-serial converter for binary mask rows. It captures one full mask row, up to IP_CHANNEL_WIDTH bits wide, in a single cycle. It then emits the row over OP_CHANNEL_WIDTH parallel lanes, one bit per lane per step. It sits between the mask-generation stage (wide row output) and the narrow downstream mask channel, and supports three image resolutions by selecting the lane length.

## Interface
Parameters:
- IP_CHANNEL_WIDTH, default 1080: width of the captured row; must be ≥ OP_CHANNEL_WIDTH*stepSel2.
- OP_CHANNEL_WIDTH, default 20: number of output lanes.
- stepSel0, default 16: lane length (bits per lane) for resolution 0 (320-bit rows).
- stepSel1, default 32: lane length for resolution 1 (640-bit rows).
- stepSel2, default 54: lane length for resolution 2 (1080-bit rows).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- DIN, input, IP_CHANNEL_WIDTH: row data, bit 0 = first pixel.
- load, input, 1: capture DIN and restart serialization.
- next, input, 1: advance to the next bit position.
- imageResolution, input, 2: 00 selects stepSel0, 01 selects stepSel1, 10 or 11 selects stepSel2.
- DOUT, output, OP_CHANNEL_WIDTH: current bit of each lane.

## Operation
- State:
  - row register, IP_CHANNEL_WIDTH bits;
  - position counter idx, width clog2(stepSel2);
  - latched step value STEP.
- Lane mapping: lane i covers row bits [i*STEP .. i*STEP+STEP-1].
- DOUT is combinational from state: DOUT[i] = row[i*STEP + idx] for i = 0..OP_CHANNEL_WIDTH-1.
  - Row bits at or above OP_CHANNEL_WIDTH*STEP are never output.
- load=1 at a rising edge:
  - row ← DIN;
  - idx ← 0;
  - STEP ← the step value selected by imageResolution at that edge.
- load=0 and next=1: idx ← idx+1. When idx == STEP-1, idx wraps to 0 and the same row re-serializes.
- load=0 and next=0: all state holds; DOUT is stable.
- Simultaneous load and next: load wins; idx = 0.
- imageResolution changes take effect only at the next load.
- No done or valid output. The consumer counts STEP advances per row; the full row is delivered after STEP distinct idx values (0..STEP-1).

## Timing
- Reset (asynchronous, effective immediately):
  - row = 0, idx = 0, STEP = stepSel2;
  - DOUT = 0.
- Load latency: DOUT shows bit position 0 of the new row immediately after the rising edge that sampled load, valid by the following falling edge.
- Each rising edge with next=1 (and load=0) advances DOUT to the next position in the same cycle; throughput is one position per cycle.
- Typical sequence, where E0 is the load edge:
  - E0: load.
  - E0–E1: position 0.
  - E1: next asserted.
  - E1–E2: position 1.
  - Edge E(k): position k.
  - A full row takes STEP cycles of output.
- The bench samples DOUT on the falling edge; outputs must be settled by then.
- Reset asserted mid-row: the row is discarded and DOUT goes to 0 asynchronously; a new load is required.

## Test plan
- Reset: assert rst with random state → DOUT = 0, idx = 0; deassert, hold next=0 → DOUT stays 0.
- Resolution 01, one-hot row:
  - Load DIN with only bit 33 set, then next for 32 cycles.
  - Lane 1 is high only at position 1 (cycle after load). All other lanes and positions read 0.
  - The reassembled 640-bit row equals DIN[639:0].
- Resolution 00 and 10, random DIN:
  - Load, then serialize 16 and 54 positions respectively.
  - Reassemble via row[i*STEP+pos] = DOUT[i].
  - Result matches DIN[319:0] and DIN[1079:0] respectively.
- Wrap: resolution 00, assert next for 17 cycles → after position 15, DOUT returns to position 0 values.
- Load priority and hold:
  - Assert load and next together mid-row → idx = 0, new row shown.
  - Deassert next for 5 cycles → DOUT unchanged.
- Resolution latch: change imageResolution from 01 to 00 mid-row → lane mapping keeps STEP = 32 until the next load.

Source files
------------

// File: rtl/mask_serializer_core.sv
// -----------------------------------------------------------------------------
// mask_serializer_core
//
// Parallel-to-serial converter for binary mask rows. A full row is captured
// in one cycle on `load`, then presented over OP_CHANNEL_WIDTH lanes, one bit
// per lane per position. Lane i owns row bits [i*STEP .. i*STEP+STEP-1], and
// the position counter walks 0..STEP-1 on each `next`, wrapping back to 0 so
// the same row re-serializes until the next load.
//
// Ports
//   clk             : rising-edge clock
//   rst             : asynchronous active-high reset (row, idx cleared,
//                     STEP = stepSel2, DOUT = 0)
//   DIN             : row data, bit 0 = first pixel
//   load            : capture DIN, restart at position 0, latch STEP
//   next            : advance one position (ignored when load is high)
//   imageResolution : 00 -> stepSel0, 01 -> stepSel1, 1x -> stepSel2
//   DOUT            : current bit of every lane (combinational from state)
//
// Flow control: there is no valid/ready pair. The producer pulses `load` once
// per row; the consumer pulses `next` once per position it has taken and
// counts STEP advances to know when the row is complete. With load and next
// both low, every bit of state (and so DOUT) holds.
// -----------------------------------------------------------------------------
module mask_serializer_core #(
  parameter int IP_CHANNEL_WIDTH = 1080,
  parameter int OP_CHANNEL_WIDTH = 20,
  parameter int stepSel0         = 16,
  parameter int stepSel1         = 32,
  parameter int stepSel2         = 54
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IP_CHANNEL_WIDTH-1:0] DIN,
  input  logic                        load,
  input  logic                        next,
  input  logic [1:0]                  imageResolution,
  output logic [OP_CHANNEL_WIDTH-1:0] DOUT
);

  // idx only ever holds 0..STEP-1, STEP itself must be able to hold stepSel2.
  localparam int IW = (stepSel2 > 1) ? $clog2(stepSel2) : 1;
  localparam int SW = $clog2(stepSel2 + 1);
  localparam int AW = (IP_CHANNEL_WIDTH > 1) ? $clog2(IP_CHANNEL_WIDTH) : 1;

  logic [IP_CHANNEL_WIDTH-1:0] r_row;
  logic [IW-1:0]               r_idx;
  logic [SW-1:0]               r_step;

  logic [SW-1:0]               w_step_sel;
  logic                        w_idx_last;

  // Lane length requested by the current resolution; only sampled on load.
  always_comb begin
    w_step_sel = SW'(stepSel2);
    case (imageResolution)
      2'b00:   w_step_sel = SW'(stepSel0);
      2'b01:   w_step_sel = SW'(stepSel1);
      default: w_step_sel = SW'(stepSel2);
    endcase
  end

  assign w_idx_last = ((32'(r_idx) + 32'd1) == 32'(r_step));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= '0;
      r_idx  <= '0;
      r_step <= SW'(stepSel2);
    end else if (load) begin
      // load has priority over next: a new row always starts at position 0.
      r_row  <= DIN;
      r_idx  <= '0;
      r_step <= w_step_sel;
    end else if (next) begin
      if (w_idx_last) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  // Per-lane bit select. Positions are computed in 32 bits so the lane base
  // multiply cannot overflow; the range guard keeps DOUT at 0 for any
  // position beyond the row, which cannot happen for legal parameter sets.
  for (genvar gi = 0; gi < OP_CHANNEL_WIDTH; gi++) begin : g_lane
    logic [31:0] w_pos;
    assign w_pos = 32'(gi) * 32'(r_step) + 32'(r_idx);
    assign DOUT[gi] = (w_pos < 32'(IP_CHANNEL_WIDTH)) ? r_row[w_pos[AW-1:0]] : 1'b0;
  end

endmodule

// File: tb/tb_mask_serializer_core.sv
module tb_mask_serializer_core;

  localparam int IP = 1080;
  localparam int OP = 20;
  localparam int S0 = 16;
  localparam int S1 = 32;
  localparam int S2 = 54;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst;
  logic [IP-1:0] din;
  logic          load;
  logic          next;
  logic [1:0]    res;
  logic [OP-1:0] dout;

  always #5 clk = ~clk;

  mask_serializer_core #(
    .IP_CHANNEL_WIDTH(IP),
    .OP_CHANNEL_WIDTH(OP),
    .stepSel0(S0),
    .stepSel1(S1),
    .stepSel2(S2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .DIN(din),
    .load(load),
    .next(next),
    .imageResolution(res),
    .DOUT(dout)
  );

  // ---------------------------------------------------------------- scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [OP-1:0] exp_q[$];
  logic [OP-1:0] last_dout;

  // Reference state: what the row/position/lane length should be.
  logic [IP-1:0] m_row;
  int            m_idx;
  int            m_step;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  function automatic int step_of(input logic [1:0] rs);
    case (rs)
      2'b00:   return S0;
      2'b01:   return S1;
      default: return S2;
    endcase
  endfunction

  // Expected lanes straight from a DIN word for a given lane length/position.
  function automatic logic [OP-1:0] lane_bits(input logic [IP-1:0] d, input int step, input int pos);
    logic [OP-1:0] r;
    r = '0;
    for (int i = 0; i < OP; i++) begin
      if (i * step + pos < IP) r[i] = d[i * step + pos];
    end
    return r;
  endfunction

  function automatic logic [OP-1:0] model_dout();
    return lane_bits(m_row, m_step, m_idx);
  endfunction

  function automatic int diff_bits(input logic [IP-1:0] a, input logic [IP-1:0] b, input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) if (a[k] !== b[k]) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_row  = '0;
    m_idx  = 0;
    m_step = S2;
  endtask

  // ---------------------------------------------------------------- driver
  // Called at a falling edge: drives inputs, updates the reference at the
  // rising edge, pushes the expectation, compares at the next falling edge.
  task automatic drive(input string name, input logic ld, input logic nx,
                       input logic [1:0] rs, input logic [IP-1:0] d,
                       input logic use_model, input logic [OP-1:0] texp);
    load = ld;
    next = nx;
    res  = rs;
    din  = d;
    @(posedge clk);
    if (ld) begin
      m_row  = d;
      m_idx  = 0;
      m_step = step_of(rs);
    end else if (nx) begin
      m_idx = (m_idx == m_step - 1) ? 0 : m_idx + 1;
    end
    if (use_model) exp_q.push_back(model_dout());
    else           exp_q.push_back(texp);
    @(negedge clk);
    load      = 1'b0;
    next      = 1'b0;
    last_dout = dout;
    check(name, 64'(dout), 64'(exp_q.pop_front()));
  endtask

  // Load a row and walk every position, rebuilding the row from the lanes.
  task automatic serialize_row(input string name, input logic [1:0] rs, input logic [IP-1:0] d);
    logic [IP-1:0] rebuilt;
    int            step;
    step    = step_of(rs);
    rebuilt = '0;
    drive({name, "_load"}, 1'b1, 1'b0, rs, d, 1'b1, '0);
    for (int i = 0; i < OP; i++) rebuilt[i * step] = last_dout[i];
    for (int pos = 1; pos < step; pos++) begin
      drive({name, "_pos"}, 1'b0, 1'b1, rs, '0, 1'b1, '0);
      for (int i = 0; i < OP; i++) rebuilt[i * step + pos] = last_dout[i];
    end
    check({name, "_reassembled_diff_bits"}, 64'(diff_bits(rebuilt, d, OP * step)), 64'd0);
  endtask

  function automatic logic [IP-1:0] rand_row();
    logic [IP-1:0] r;
    for (int k = 0; k < IP; k++) r[k] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [IP-1:0] one_hot(input int b);
    logic [IP-1:0] r;
    r = '0;
    if (b >= 0) r[b] = 1'b1;
    return r;
  endfunction

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic          ld;
    logic          nx;
    logic [1:0]    rs;
    int            bit_set;   // -1: DIN all zero
    logic [OP-1:0] expv;
  } vec_t;

  vec_t tbl[12];

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [IP-1:0] row_a;
    logic [IP-1:0] row_b;
    logic [IP-1:0] row_c;
    logic [OP-1:0] held;

    // Hand-computed lane patterns for one-hot rows.
    tbl[0]  = '{1'b1, 1'b0, 2'd1,   33, 20'h00000}; // res1: lane1 pos1, at pos0
    tbl[1]  = '{1'b0, 1'b1, 2'd1,   -1, 20'h00002}; // pos1
    tbl[2]  = '{1'b0, 1'b1, 2'd1,   -1, 20'h00000}; // pos2
    tbl[3]  = '{1'b1, 1'b0, 2'd0,   33, 20'h00000}; // res0: lane2 pos1
    tbl[4]  = '{1'b0, 1'b1, 2'd0,   -1, 20'h00004};
    tbl[5]  = '{1'b1, 1'b0, 2'd2,   55, 20'h00000}; // res2: lane1 pos1
    tbl[6]  = '{1'b0, 1'b1, 2'd2,   -1, 20'h00002};
    tbl[7]  = '{1'b1, 1'b0, 2'd3,    0, 20'h00001}; // res3 behaves as res2
    tbl[8]  = '{1'b1, 1'b1, 2'd0,   17, 20'h00000}; // load beats next: pos0
    tbl[9]  = '{1'b0, 1'b1, 2'd0,   -1, 20'h00002}; // then pos1: lane1
    tbl[10] = '{1'b1, 1'b0, 2'd2, 1079, 20'h00000}; // last row bit, lane19 pos53
    tbl[11] = '{1'b1, 1'b0, 2'd1,   64, 20'h00004}; // res1: lane2 pos0

    rst  = 1'b1;
    load = 1'b0;
    next = 1'b0;
    res  = 2'd0;
    din  = rand_row();
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dout", 64'(dout), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) drive("post_reset_hold", 1'b0, 1'b0, 2'd0, rand_row(), 1'b1, '0);
    drive("post_reset_next", 1'b0, 1'b1, 2'd0, '0, 1'b1, '0);

    // Table-driven vectors
    for (int v = 0; v < 12; v++) begin
      drive($sformatf("tbl%0d", v), tbl[v].ld, tbl[v].nx, tbl[v].rs,
            one_hot(tbl[v].bit_set), 1'b0, tbl[v].expv);
    end

    // One-hot row at res 01, and random rows at res 00 / 10
    serialize_row("onehot_res1", 2'd1, one_hot(33));
    row_a = rand_row();
    serialize_row("rand_res0", 2'd0, row_a);

    // Wrap: one more next after position 15 returns to position 0
    drive("wrap_pos0", 1'b0, 1'b1, 2'd0, '0, 1'b0, lane_bits(row_a, S0, 0));
    drive("wrap_pos1", 1'b0, 1'b1, 2'd0, '0, 1'b0, lane_bits(row_a, S0, 1));

    serialize_row("rand_res2", 2'd2, rand_row());

    // Load priority mid-row, then hold
    row_a = rand_row();
    row_b = rand_row();
    drive("prio_load_a", 1'b1, 1'b0, 2'd2, row_a, 1'b0, lane_bits(row_a, S2, 0));
    for (int c = 0; c < 10; c++) drive("prio_adv", 1'b0, 1'b1, 2'd2, '0, 1'b1, '0);
    drive("prio_load_next", 1'b1, 1'b1, 2'd2, row_b, 1'b0, lane_bits(row_b, S2, 0));
    held = lane_bits(row_b, S2, 0);
    for (int c = 0; c < 5; c++) drive("hold", 1'b0, 1'b0, 2'd2, rand_row(), 1'b0, held);
    drive("after_hold", 1'b0, 1'b1, 2'd2, '0, 1'b0, lane_bits(row_b, S2, 1));

    // Resolution latch: STEP stays 32 until the next load
    row_c = rand_row();
    drive("latch_load", 1'b1, 1'b0, 2'd1, row_c, 1'b0, lane_bits(row_c, S1, 0));
    for (int p = 1; p <= 3; p++)
      drive("latch_res1", 1'b0, 1'b1, 2'd1, '0, 1'b0, lane_bits(row_c, S1, p));
    for (int p = 4; p <= 6; p++)
      drive("latch_res0_pending", 1'b0, 1'b1, 2'd0, '0, 1'b0, lane_bits(row_c, S1, p));
    drive("latch_reload", 1'b1, 1'b0, 2'd0, row_c, 1'b0, lane_bits(row_c, S0, 0));
    drive("latch_reload_pos1", 1'b0, 1'b1, 2'd0, '0, 1'b0, lane_bits(row_c, S0, 1));

    // Asynchronous reset mid-row
    drive("ones_load", 1'b1, 1'b0, 2'd2, '1, 1'b0, '1);
    drive("ones_pos1", 1'b0, 1'b1, 2'd2, '0, 1'b0, '1);
    #2 rst = 1'b1;
    #1 check("async_reset_dout", 64'(dout), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive("after_async_next", 1'b0, 1'b1, 2'd2, '0, 1'b0, '0);
    drive("after_async_hold", 1'b0, 1'b0, 2'd2, '1, 1'b0, '0);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
